// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller that borrows the shared ALU adder for each
// partial-product accumulation. It returns the low WIDTH bits of a*b after WIDTH iterations.
module alu_mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [2:0]       alu_opc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_w
);

    localparam logic [2:0]       OPC_ADD = 3'b011;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_nxt;

    // The ALU sums acc + mcand. That sum is only kept when the current multiplier bit is set.
    assign acc_nxt = mplier[0] ? alu_w : acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state  <= S_RUN;
                        acc    <= '0;
                        mcand  <= a;
                        mplier <= b;
                        cnt    <= '0;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        product <= acc_nxt;
                        state   <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);
    assign alu_opc = OPC_ADD;
    assign alu_a   = busy ? acc   : '0;
    assign alu_b   = busy ? mcand : '0;

endmodule
